// File: rtl/vrf_operand_collector_pkg.sv
// Shared widths and types for the VRF operand collector.
// The FSM state enum and the latched uop record live here.
package vrf_operand_collector_pkg;

  localparam int unsigned RPORT_NUM = 3;
  localparam int unsigned VADDR_W   = 6;
  localparam int unsigned DATA_W    = 256;
  localparam int unsigned TAG_W     = 8;
  localparam int unsigned CNT_W     = 16;

  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StOut
  } opc_state_e;

  typedef struct packed {
    logic [RPORT_NUM-1:0]         need;
    logic [RPORT_NUM*VADDR_W-1:0] vaddr;
    logic [TAG_W-1:0]             tag;
  } opc_uop_t;

endpackage

// File: rtl/vrf_opc_slot.sv
// One read-port capture register with its got flag.
// The first capture after a clear wins; later captures are ignored until the next clear.
module vrf_opc_slot #(
  parameter int unsigned DataW = 256
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             cap,
  input  logic [DataW-1:0] wdata,
  output logic             got,
  output logic [DataW-1:0] data
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      got  <= 1'b0;
      data <= '0;
    end else if (clr) begin
      got  <= 1'b0;
      data <= '0;
    end else if (cap && !got) begin
      got  <= 1'b1;
      data <= wdata;
    end
  end

endmodule

// File: rtl/vrf_operand_collector.sv
// Collects one vector uop's source operands from the VRF read ports and hands the
// complete bundle to the execution unit over valid/ready.
module vrf_operand_collector
  import vrf_operand_collector_pkg::*;
(
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [RPORT_NUM-1:0]         in_need,
  input  logic [RPORT_NUM*VADDR_W-1:0] in_vaddr,
  input  logic [TAG_W-1:0]             in_tag,
  output logic [RPORT_NUM-1:0]         vrf_req,
  output logic [RPORT_NUM*VADDR_W-1:0] vrf_vaddr,
  input  logic                         vrf_busy,
  input  logic [RPORT_NUM-1:0]         vrf_rvld,
  input  logic [RPORT_NUM*DATA_W-1:0]  vrf_rdata,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RPORT_NUM*DATA_W-1:0]  out_data,
  output logic [TAG_W-1:0]             out_tag,
  output logic [CNT_W-1:0]             stall_cnt
);

  opc_state_e           state_q, state_d;
  opc_uop_t             uop_q;
  logic [CNT_W-1:0]     stall_q;
  logic [RPORT_NUM-1:0] got, cap;
  logic                 accept, collecting, done, clr;

  // Busy only tells us the VRF is still arbitrating; requests are held regardless.
  logic unused_busy;
  assign unused_busy = vrf_busy;

  assign collecting = (state_q == StCollect);
  assign in_ready   = !flush && ((state_q == StIdle) || ((state_q == StOut) && out_ready));
  assign accept     = in_valid && in_ready;
  assign cap        = {RPORT_NUM{collecting}} & vrf_rvld & uop_q.need & ~got;
  assign done       = ((got | cap) == uop_q.need);
  assign clr        = accept || flush;

  assign vrf_req   = collecting ? (uop_q.need & ~got) : '0;
  assign vrf_vaddr = uop_q.vaddr;
  assign out_valid = (state_q == StOut);
  assign out_tag   = uop_q.tag;
  assign stall_cnt = stall_q;

  for (genvar i = 0; i < RPORT_NUM; i++) begin : g_slot
    vrf_opc_slot #(
      .DataW(DATA_W)
    ) u_slot (
      .clk  (clk),
      .rstn (rstn),
      .clr  (clr),
      .cap  (cap[i]),
      .wdata(vrf_rdata[i*DATA_W +: DATA_W]),
      .got  (got[i]),
      .data (out_data[i*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) state_d = (in_need != '0) ? StCollect : StOut;
        end
        StCollect: begin
          if (done) state_d = StOut;
        end
        StOut: begin
          if (out_ready) begin
            if (accept) state_d = (in_need != '0) ? StCollect : StOut;
            else        state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      uop_q <= '0;
    end else if (flush) begin
      uop_q.need <= '0;
    end else if (accept) begin
      uop_q <= '{need: in_need, vaddr: in_vaddr, tag: in_tag};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (collecting && !done && !flush && (stall_q != '1)) begin
      stall_q <= stall_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_vrf_operand_collector.sv
// Self-checking bench for vrf_operand_collector: directed scenarios plus a randomized
// run against a per-uop transaction model.
module tb_vrf_operand_collector;

  logic         clk = 1'b0;
  logic         rstn, flush, in_valid, in_ready, vrf_busy, out_valid, out_ready;
  logic [2:0]   in_need, vrf_req, vrf_rvld;
  logic [17:0]  in_vaddr, vrf_vaddr;
  logic [7:0]   in_tag, out_tag;
  logic [767:0] vrf_rdata, out_data;
  logic [15:0]  stall_cnt;
  int total = 0;
  int bad = 0;

  vrf_operand_collector dut (
    .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_need(in_need), .in_vaddr(in_vaddr), .in_tag(in_tag), .vrf_req(vrf_req),
    .vrf_vaddr(vrf_vaddr), .vrf_busy(vrf_busy), .vrf_rvld(vrf_rvld), .vrf_rdata(vrf_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_need = 0; in_vaddr = 0; in_tag = 0;
    vrf_busy = 0; vrf_rvld = 0; vrf_rdata = 0; out_ready = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rstn = 0;
    #12;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (vrf_req !== 3'b0) begin bad++; $display("FAIL reset_vrf_req got=%b exp=0", vrf_req); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (out_data !== 768'b0) begin bad++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
    total++; if (out_tag !== 8'h0) begin bad++; $display("FAIL reset_out_tag got=%h exp=0", out_tag); end
    total++; if (stall_cnt !== 16'h0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
    @(negedge clk); rstn = 1;
    @(negedge clk);
  endtask

  task automatic test_two_port();
    logic [767:0] d, exp;
    d = {rnd256(), rnd256(), rnd256()};
    in_valid = 1; in_need = 3'b011; in_vaddr = {6'd0, 6'd5, 6'd9}; in_tag = 8'hA5;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL two_in_ready got=%b exp=1", in_ready); end
    @(negedge clk); in_valid = 0;
    #1;
    total++; if (vrf_req !== 3'b011) begin bad++; $display("FAIL two_req got=%b exp=011", vrf_req); end
    total++; if (vrf_vaddr !== {6'd0, 6'd5, 6'd9}) begin bad++; $display("FAIL two_vaddr got=%h exp=%h", vrf_vaddr, {6'd0, 6'd5, 6'd9}); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL two_early_valid got=%b exp=0", out_valid); end
    vrf_rvld = 3'b011; vrf_rdata = d;
    @(negedge clk); vrf_rvld = 0;
    exp = {256'b0, d[511:0]};
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL two_out_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== exp) begin bad++; $display("FAIL two_out_data got=%h exp=%h", out_data, exp); end
    total++; if (out_tag !== 8'hA5) begin bad++; $display("FAIL two_out_tag got=%h exp=a5", out_tag); end
    total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL two_stall got=%0d exp=0", stall_cnt); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL two_in_ready_out got=%b exp=0", in_ready); end
    out_ready = 1;
    @(negedge clk); out_ready = 0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL two_retire got=%b exp=0", out_valid); end
  endtask

  task automatic test_three_port_staggered();
    logic [767:0] d, dup, exp;
    d = {rnd256(), rnd256(), rnd256()};
    dup = {rnd256(), rnd256(), rnd256()};
    @(negedge clk);
    in_valid = 1; in_need = 3'b111; in_vaddr = {6'd3, 6'd2, 6'd1}; in_tag = 8'h3C;
    @(negedge clk); in_valid = 0;
    #1;
    total++; if (vrf_req !== 3'b111) begin bad++; $display("FAIL stag_req0 got=%b exp=111", vrf_req); end
    vrf_rvld = 3'b001; vrf_rdata = d;
    @(negedge clk);
    #1;
    total++; if (vrf_req !== 3'b110) begin bad++; $display("FAIL stag_req1 got=%b exp=110", vrf_req); end
    // port 0 returns again with different data: must be ignored
    vrf_rvld = 3'b101; vrf_busy = 1; vrf_rdata = {d[767:512], dup[511:256], dup[255:0]};
    @(negedge clk);
    #1;
    total++; if (vrf_req !== 3'b010) begin bad++; $display("FAIL stag_req2 got=%b exp=010", vrf_req); end
    vrf_rvld = 3'b010; vrf_busy = 0; vrf_rdata = d;
    @(negedge clk); vrf_rvld = 0;
    exp = d;
    #1;
    total++; if (vrf_req !== 3'b000) begin bad++; $display("FAIL stag_req3 got=%b exp=000", vrf_req); end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stag_valid got=%b exp=1", out_valid); end
    total++; if (stall_cnt !== 16'd2) begin bad++; $display("FAIL stag_stall got=%0d exp=2", stall_cnt); end
    total++; if (out_data !== exp) begin bad++; $display("FAIL stag_data got=%h exp=%h", out_data, exp); end
    out_ready = 1;
    @(negedge clk); out_ready = 0;
  endtask

  task automatic test_zero_src();
    in_valid = 1; in_need = 3'b000; in_tag = 8'h11;
    @(negedge clk); in_valid = 0;
    #1;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL zero_valid got=%b exp=1", out_valid); end
    total++; if (vrf_req !== 3'b000) begin bad++; $display("FAIL zero_req got=%b exp=000", vrf_req); end
    total++; if (out_data !== 768'b0) begin bad++; $display("FAIL zero_data got=%h exp=0", out_data); end
    total++; if (out_tag !== 8'h11) begin bad++; $display("FAIL zero_tag got=%h exp=11", out_tag); end
    out_ready = 1;
    @(negedge clk); out_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [767:0] d, exp;
    d = {rnd256(), rnd256(), rnd256()};
    in_valid = 1; in_need = 3'b001; in_vaddr = 18'h1; in_tag = 8'h21;
    @(negedge clk);
    in_need = 3'b010; in_vaddr = 18'h80; in_tag = 8'h22;
    vrf_rvld = 3'b001; vrf_rdata = d;
    @(negedge clk); vrf_rvld = 0; vrf_rdata = {rnd256(), rnd256(), rnd256()};
    exp = {512'b0, d[255:0]};
    for (int c = 0; c < 5; c++) begin
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== exp || out_tag !== 8'h21)
        begin bad++; $display("FAIL hold_bundle cyc=%0d valid=%b tag=%h data=%h exp_data=%h", c, out_valid, out_tag, out_data, exp); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
      @(negedge clk);
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    @(negedge clk); out_ready = 0; in_valid = 0;
    #1;
    total++; if (vrf_req !== 3'b010 || out_tag !== 8'h22 || out_valid !== 1'b0)
      begin bad++; $display("FAIL b2b_new req=%b tag=%h valid=%b exp=010/22/0", vrf_req, out_tag, out_valid); end
    vrf_rvld = 3'b010;
    @(negedge clk); vrf_rvld = 0; out_ready = 1;
    @(negedge clk); out_ready = 0;
  endtask

  task automatic test_flush();
    logic [767:0] d, late, exp;
    d = {rnd256(), rnd256(), rnd256()};
    late = {rnd256(), rnd256(), rnd256()};
    in_valid = 1; in_need = 3'b111; in_vaddr = 18'h3_1234; in_tag = 8'h5A;
    @(negedge clk); in_valid = 0;
    vrf_rvld = 3'b001; vrf_rdata = d;
    @(negedge clk); vrf_rvld = 0;
    flush = 1; in_valid = 1; in_need = 3'b001;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b exp=0", in_ready); end
    @(negedge clk); flush = 0; in_valid = 0;
    #1;
    total++; if (vrf_req !== 3'b000 || out_valid !== 1'b0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL flush_idle req=%b valid=%b rdy=%b exp=000/0/1", vrf_req, out_valid, in_ready); end
    vrf_rvld = 3'b010; vrf_rdata = late;
    @(negedge clk); vrf_rvld = 0;
    #1;
    total++; if (out_valid !== 1'b0 || vrf_req !== 3'b000)
      begin bad++; $display("FAIL flush_late valid=%b req=%b exp=0/000", out_valid, vrf_req); end
    in_valid = 1; in_need = 3'b010; in_tag = 8'h5B;
    @(negedge clk); in_valid = 0;
    d = {rnd256(), rnd256(), rnd256()};
    vrf_rvld = 3'b010; vrf_rdata = d;
    @(negedge clk); vrf_rvld = 0;
    exp = {256'b0, d[511:256], 256'b0};
    #1;
    total++; if (out_valid !== 1'b1 || out_data !== exp)
      begin bad++; $display("FAIL flush_next valid=%b data=%h exp=%h", out_valid, out_data, exp); end
    out_ready = 1;
    @(negedge clk); out_ready = 0;
  endtask

  task automatic test_async_reset();
    logic [767:0] d;
    d = {rnd256(), rnd256(), rnd256()};
    in_valid = 1; in_need = 3'b011; in_tag = 8'h77;
    @(negedge clk); in_valid = 0;
    vrf_rvld = 3'b001; vrf_rdata = d;
    @(negedge clk); vrf_rvld = 0;
    #1;
    total++; if (out_data[255:0] !== d[255:0]) begin bad++; $display("FAIL ar_partial got=%h exp=%h", out_data[255:0], d[255:0]); end
    #1 rstn = 0;
    #1;
    total++; if (vrf_req !== 3'b0 || out_valid !== 1'b0 || out_data !== 768'b0 || out_tag !== 8'h0 ||
                 stall_cnt !== 16'h0 || in_ready !== 1'b1)
      begin bad++; $display("FAIL async_reset req=%b valid=%b tag=%h stall=%0d rdy=%b data=%h", vrf_req, out_valid, out_tag, stall_cnt, in_ready, out_data); end
    vrf_rvld = 3'b010;
    @(negedge clk); vrf_rvld = 0; rstn = 1;
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b0 || vrf_req !== 3'b0) begin bad++; $display("FAIL ar_after valid=%b req=%b exp=0/000", out_valid, vrf_req); end
  endtask

  task automatic test_random(input int n);
    logic [2:0]   need, got, rv;
    logic [17:0]  va;
    logic [7:0]   tag;
    logic [767:0] exp, rd;
    int k, budget;
    for (int u = 0; u < n; u++) begin
      need = 3'($urandom_range(0, 7)); va = 18'($urandom()); tag = 8'($urandom());
      in_valid = 1; in_need = need; in_vaddr = va; in_tag = tag;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rnd_in_ready u=%0d got=%b exp=1", u, in_ready); end
      @(negedge clk); in_valid = 0;
      got = 0; k = 0; budget = 0; exp = 0;
      while (got != need && budget < 200) begin
        #1;
        total++; if (vrf_req !== (need & ~got) || vrf_vaddr !== va)
          begin bad++; $display("FAIL rnd_req u=%0d got=%b exp=%b vaddr=%h exp=%h", u, vrf_req, need & ~got, vrf_vaddr, va); end
        rv = 3'($urandom_range(0, 7)); rd = {rnd256(), rnd256(), rnd256()};
        vrf_rvld = rv; vrf_rdata = rd; vrf_busy = 1'($urandom());
        for (int i = 0; i < 3; i++)
          if (rv[i] && need[i] && !got[i]) begin
            exp[i*256 +: 256] = rd[i*256 +: 256];
            got[i] = 1'b1;
          end
        if (got != need) k++;
        budget++;
        @(negedge clk);
      end
      vrf_rvld = 0; vrf_busy = 0;
      if (budget >= 200) begin
        total++; bad++; $display("FAIL rnd_timeout u=%0d", u);
      end
      repeat ($urandom_range(0, 2)) begin
        #1;
        total++; if (out_valid !== 1'b1 || out_data !== exp || out_tag !== tag || stall_cnt !== 16'(k))
          begin bad++; $display("FAIL rnd_bundle u=%0d valid=%b tag=%h/%h stall=%0d/%0d data=%h exp=%h", u, out_valid, out_tag, tag, stall_cnt, k, out_data, exp); end
        @(negedge clk);
      end
      #1;
      total++; if (out_valid !== 1'b1 || out_data !== exp || out_tag !== tag || stall_cnt !== 16'(k))
        begin bad++; $display("FAIL rnd_final u=%0d valid=%b tag=%h/%h stall=%0d/%0d data=%h exp=%h", u, out_valid, out_tag, tag, stall_cnt, k, out_data, exp); end
      out_ready = 1;
      @(negedge clk); out_ready = 0;
    end
  endtask

  initial begin
    test_reset();
    test_two_port();
    test_three_port_staggered();
    test_zero_src();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_random(60);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
